// File: rtl/reg8_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg8_share_arbiter_if
// Bundle between N_REQ producers and the shared 8-bit register arbiter.
//   req        : per-requester write request (level, held until ack)
//   wdata_flat : requester i data in bits [8*i+7:8*i]
//   ack        : one-hot, one-cycle pulse; that requester's data was written
//   rdata      : current shared register contents
//   owner      : index of the last requester written
//   busy       : cooldown active, no grants possible
// Modports: master = producer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface reg8_share_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int OW = (N_REQ <= 2) ? 1 : $clog2(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] wdata_flat;
    logic [N_REQ-1:0]   ack;
    logic [7:0]         rdata;
    logic [OW-1:0]      owner;
    logic               busy;

    modport master (
        output req, wdata_flat,
        input  ack, rdata, owner, busy
    );

    modport slave (
        input  req, wdata_flat,
        output ack, rdata, owner, busy
    );
endinterface

// File: rtl/reg8_share_arbiter.sv
// ---------------------------------------------------------------------------
// reg8_share_arbiter
// Round-robin arbiter that shares one 8-bit register among N_REQ producers.
// A granted requester's data is captured into the register and acknowledged
// with a one-cycle pulse; the register is then held for HOLD_CYC cycles
// before the next grant so downstream logic sees a stable value.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : reg8_share_arbiter_if.slave (req, wdata_flat in; ack, rdata,
//         owner, busy out)
// ---------------------------------------------------------------------------
module reg8_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    reg8_share_arbiter_if.slave  bus
);
    localparam int OW = (N_REQ <= 2) ? 1 : $clog2(N_REQ);
    localparam logic [3:0] HOLD_INIT = 4'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [OW-1:0]    ptr_reg, ptr_next;
    logic [OW-1:0]    owner_reg, owner_next;
    logic [N_REQ-1:0] ack_reg, ack_next;
    logic [7:0]       rdata_reg, rdata_next;

    logic [N_REQ-1:0] elig;
    logic             sel_valid;
    logic [OW-1:0]    sel_idx;
    logic [7:0]       wdata_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign wdata_arr[gi] = bus.wdata_flat[8*gi +: 8];
    end

    // A requester whose ack is currently high has already been served for
    // this request; masking it guarantees one write per ack.
    assign elig = bus.req & ~ack_reg;

    // First eligible index searching ptr, ptr+1, ... with wrap-around.
    always_comb begin
        int idx;
        sel_valid = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!sel_valid && elig[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = OW'(idx);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        rdata_next = rdata_reg;
        ack_next   = '0;
        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    rdata_next = wdata_arr[sel_idx];
                    ack_next   = N_REQ'(1) << sel_idx;
                    owner_next = sel_idx;
                    ptr_next   = (int'(sel_idx) == N_REQ - 1) ? '0 : sel_idx + OW'(1);
                    if (HOLD_CYC > 0) begin
                        state_next = HOLD;
                        cnt_next   = HOLD_INIT;
                    end
                end
            end
            HOLD: begin
                // Loaded with HOLD_CYC-1, so leaving at zero gives exactly
                // HOLD_CYC cycles of cooldown.
                if (cnt_reg == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
            owner_reg <= '0;
            ack_reg   <= '0;
            rdata_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            ack_reg   <= ack_next;
            rdata_reg <= rdata_next;
        end
    end

    assign bus.ack   = ack_reg;
    assign bus.rdata = rdata_reg;
    assign bus.owner = owner_reg;
    assign bus.busy  = (state_reg == HOLD);
endmodule

// File: tb/tb_reg8_share_arbiter.sv
module tb_reg8_share_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg8_share_arbiter_if #(.N_REQ(4)) bus2 ();
    reg8_share_arbiter_if #(.N_REQ(4)) bus0 ();

    reg8_share_arbiter #(.N_REQ(4), .HOLD_CYC(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    reg8_share_arbiter #(.N_REQ(4), .HOLD_CYC(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] all_data [4];
    int         fair_ord [4];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus2.req = '0;
        bus2.wdata_flat = '0;
        bus0.req = '0;
        bus0.wdata_flat = '0;
        all_data[0] = 8'h11; all_data[1] = 8'h22;
        all_data[2] = 8'h33; all_data[3] = 8'h44;
        fair_ord[0] = 3; fair_ord[1] = 0; fair_ord[2] = 3; fair_ord[3] = 0;

        // Reset state
        cyc(2);
        check("reset_rdata", 32'(bus2.rdata), 32'h00);
        check("reset_ack",   32'(bus2.ack),   32'h0);
        check("reset_owner", 32'(bus2.owner), 32'h0);
        check("reset_busy",  32'(bus2.busy),  32'h0);
        rst = 1'b1;

        // Single request from requester 2, data A5
        bus2.wdata_flat[23:16] = 8'hA5;
        bus2.req = 4'b0100;
        cyc(1);
        $display("txn single: ack=%b rdata=%h owner=%0d", bus2.ack, bus2.rdata, bus2.owner);
        check("single_rdata", 32'(bus2.rdata), 32'hA5);
        check("single_ack",   32'(bus2.ack),   32'h4);
        check("single_owner", 32'(bus2.owner), 32'h2);
        check("single_busy1", 32'(bus2.busy),  32'h1);
        bus2.req = 4'b0000;
        cyc(1);
        check("single_ack_off", 32'(bus2.ack),  32'h0);
        check("single_busy2",   32'(bus2.busy), 32'h1);
        cyc(1);
        check("single_idle", 32'(bus2.busy),  32'h0);
        check("single_keep", 32'(bus2.rdata), 32'hA5);

        // Withdrawal: ptr is 3, requester 1 granted, then req[2] raised
        // during HOLD and dropped before IDLE.
        bus2.wdata_flat[15:8] = 8'h77;
        bus2.req = 4'b0010;
        cyc(1);
        $display("txn wd_grant: ack=%b rdata=%h owner=%0d", bus2.ack, bus2.rdata, bus2.owner);
        check("wd_grant_ack",   32'(bus2.ack),   32'h2);
        check("wd_grant_rdata", 32'(bus2.rdata), 32'h77);
        bus2.req = 4'b0100;
        bus2.wdata_flat[23:16] = 8'h99;
        cyc(1);
        bus2.req = 4'b0000;
        check("wd_hold_busy", 32'(bus2.busy), 32'h1);
        cyc(1);
        check("wd_idle", 32'(bus2.busy), 32'h0);
        cyc(1);
        $display("txn withdraw: ack=%b rdata=%h", bus2.ack, bus2.rdata);
        check("wd_no_ack", 32'(bus2.ack),   32'h0);
        check("wd_rdata",  32'(bus2.rdata), 32'h77);

        // Reset mid-HOLD: ptr is 2, requester 2 granted with 5A
        bus2.wdata_flat[23:16] = 8'h5A;
        bus2.req = 4'b0100;
        cyc(1);
        check("rh_grant_rdata", 32'(bus2.rdata), 32'h5A);
        check("rh_grant_owner", 32'(bus2.owner), 32'h2);
        bus2.req = 4'b0000;
        #2;
        rst = 1'b0;
        #1;
        $display("txn async_reset: ack=%b rdata=%h owner=%0d busy=%b", bus2.ack, bus2.rdata, bus2.owner, bus2.busy);
        check("rh_rdata", 32'(bus2.rdata), 32'h00);
        check("rh_ack",   32'(bus2.ack),   32'h0);
        check("rh_busy",  32'(bus2.busy),  32'h0);
        check("rh_owner", 32'(bus2.owner), 32'h0);
        cyc(1);
        rst = 1'b1;

        // All four requesting, each held until its own ack; ptr restarts at 0
        for (int i = 0; i < 4; i++) bus2.wdata_flat[8*i +: 8] = all_data[i];
        bus2.req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            cyc(1);
            $display("txn all4 grant %0d: ack=%b rdata=%h owner=%0d", g, bus2.ack, bus2.rdata, bus2.owner);
            check($sformatf("all4_ack%0d", g),   32'(bus2.ack),   32'(4'b0001 << g));
            check($sformatf("all4_rdata%0d", g), 32'(bus2.rdata), 32'(all_data[g]));
            check($sformatf("all4_owner%0d", g), 32'(bus2.owner), 32'(g));
            bus2.req[g] = 1'b0;
            cyc(1);
            check($sformatf("all4_gap1_%0d", g), 32'(bus2.ack), 32'h0);
            cyc(1);
            check($sformatf("all4_gap2_%0d", g), 32'(bus2.ack), 32'h0);
        end

        // Fairness: one grant to requester 0 moves ptr to 1, then req[0]
        // and req[3] are held continuously.
        bus2.wdata_flat[7:0] = 8'h01;
        bus2.req = 4'b0001;
        cyc(1);
        check("fair_setup_ack", 32'(bus2.ack), 32'h1);
        bus2.req = 4'b0000;
        cyc(2);
        bus2.wdata_flat[7:0]   = 8'hA0;
        bus2.wdata_flat[31:24] = 8'hD3;
        bus2.req = 4'b1001;
        for (int g = 0; g < 4; g++) begin
            cyc(1);
            $display("txn fair grant %0d: ack=%b rdata=%h owner=%0d", g, bus2.ack, bus2.rdata, bus2.owner);
            check($sformatf("fair_ack%0d", g),   32'(bus2.ack),   32'(4'b0001 << fair_ord[g]));
            check($sformatf("fair_owner%0d", g), 32'(bus2.owner), 32'(fair_ord[g]));
            check($sformatf("fair_rdata%0d", g), 32'(bus2.rdata), (fair_ord[g] == 3) ? 32'hD3 : 32'hA0);
            cyc(2);
        end
        bus2.req = 4'b0000;

        // HOLD_CYC=0 instance, req[1] held continuously
        bus0.wdata_flat[15:8] = 8'hC3;
        bus0.req = 4'b0010;
        for (int g = 0; g < 3; g++) begin
            cyc(1);
            $display("txn hold0 pulse %0d: ack=%b rdata=%h busy=%b", g, bus0.ack, bus0.rdata, bus0.busy);
            check($sformatf("h0_ack%0d", g),   32'(bus0.ack),   32'h2);
            check($sformatf("h0_rdata%0d", g), 32'(bus0.rdata), 32'hC3);
            check($sformatf("h0_busy%0d", g),  32'(bus0.busy),  32'h0);
            cyc(1);
            check($sformatf("h0_gap%0d", g),   32'(bus0.ack),   32'h0);
            check($sformatf("h0_gbusy%0d", g), 32'(bus0.busy),  32'h0);
        end
        bus0.req = 4'b0000;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
